// File: rtl/cv32e41p_fpu_pkg.sv
// Shared FPU types: operations, formats, opgroups and the queued request record.
package cv32e41p_fpu_pkg;

    localparam int unsigned FLEN         = 32;
    localparam int unsigned NUM_OPERANDS = 3;
    localparam int unsigned TAG_W        = 5;

    typedef enum logic [3:0] {
        FMADD, FNMSUB, ADD, MUL, DIV, SQRT, SGNJ, MINMAX, CMP, CLASSIFY,
        F2F, F2I, I2F, CPKAB, CPKCD
    } operation_e;

    typedef enum logic [2:0] {FP32, FP64, FP16, FP8, FP16ALT} fp_format_e;

    typedef enum logic [1:0] {INT8, INT16, INT32, INT64} int_format_e;

    typedef enum logic [1:0] {ADDMUL, DIVSQRT, NONCOMP, CONV} opgroup_e;

    typedef struct packed {
        operation_e                    op;
        logic                          op_mod;
        fp_format_e                    src_fmt;
        fp_format_e                    dst_fmt;
        int_format_e                   int_fmt;
        logic [2:0]                    rm;
        logic [TAG_W-1:0]              tag;
        logic [NUM_OPERANDS*FLEN-1:0]  operands;
    } fpu_req_t;

    function automatic opgroup_e get_opgroup(operation_e op);
        case (op)
            FMADD, FNMSUB, ADD, MUL:         return ADDMUL;
            DIV, SQRT:                       return DIVSQRT;
            F2F, F2I, I2F, CPKAB, CPKCD:     return CONV;
            default:                         return NONCOMP;
        endcase
    endfunction

    // Only FP32, FP16, FP8 and FP16ALT are supported by this FPU build.
    function automatic logic is_bad_fmt(fp_format_e fmt);
        return (fmt == FP64) || (fmt > FP16ALT);
    endfunction

endpackage

// File: rtl/cv32e41p_fpu_req_fifo.sv
// DEPTH-entry FIFO of fpu_req_t with wrapping pointers and an occupancy count.
module cv32e41p_fpu_req_fifo
    import cv32e41p_fpu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     i_flush,
    input  logic     i_push,
    input  logic     i_pop,
    input  fpu_req_t i_data,
    output fpu_req_t o_data,
    output logic     o_full,
    output logic     o_empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    fpu_req_t         r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;

    logic w_push;
    logic w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push & ~o_full & ~i_flush;
    assign w_pop   = i_pop & ~o_empty;
    assign o_data  = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_data;
    end

endmodule

// File: rtl/cv32e41p_fpu_req_queue.sv
// FP request queue toward the FPU with issue throttling and opgroup classification.
// Optional format rejection is enabled by defining CV32E41P_FPU_FMT_CHECK_EN.
module cv32e41p_fpu_req_queue
    import cv32e41p_fpu_pkg::*;
#(
    parameter int unsigned FLEN            = cv32e41p_fpu_pkg::FLEN,
    parameter int unsigned NUM_OPERANDS    = cv32e41p_fpu_pkg::NUM_OPERANDS,
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned TAG_W           = cv32e41p_fpu_pkg::TAG_W,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [3:0]                   in_op_i,
    input  logic                         in_op_mod_i,
    input  logic [2:0]                   in_src_fmt_i,
    input  logic [2:0]                   in_dst_fmt_i,
    input  logic [1:0]                   in_int_fmt_i,
    input  logic [2:0]                   in_rm_i,
    input  logic [TAG_W-1:0]             in_tag_i,
    input  logic [NUM_OPERANDS*FLEN-1:0] in_operands_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output fpu_req_t                     out_req_o,
    output logic [1:0]                   out_opgroup_o,
    input  logic                         resp_valid_i,
    output logic [3:0]                   outstanding_o,
    output logic                         empty_o,
    output logic                         fmt_err_o
);

    fpu_req_t   w_req;
    logic       w_full;
    logic       w_empty;
    logic       w_accept;
    logic       w_bad;
    logic       w_push;
    logic       w_pop;
    logic       w_dec;
    logic [3:0] r_outstanding;

    always_comb begin
        w_req          = '0;
        w_req.op       = operation_e'(in_op_i);
        w_req.op_mod   = in_op_mod_i;
        w_req.src_fmt  = fp_format_e'(in_src_fmt_i);
        w_req.dst_fmt  = fp_format_e'(in_dst_fmt_i);
        w_req.int_fmt  = int_format_e'(in_int_fmt_i);
        w_req.rm       = in_rm_i;
        w_req.tag      = in_tag_i;
        w_req.operands = in_operands_i;
    end

    assign in_ready_o = ~w_full & ~rst;
    assign w_accept   = in_valid_i & in_ready_o;

`ifdef CV32E41P_FPU_FMT_CHECK_EN
    logic r_fmt_err;

    assign w_bad = is_bad_fmt(w_req.src_fmt) | is_bad_fmt(w_req.dst_fmt);

    // Rejected requests still complete the handshake; the error is flagged a cycle later.
    always_ff @(posedge clk) begin
        if (rst) r_fmt_err <= 1'b0;
        else     r_fmt_err <= w_accept & w_bad;
    end

    assign fmt_err_o = r_fmt_err;
`else
    assign w_bad     = 1'b0;
    assign fmt_err_o = 1'b0;
`endif

    assign w_push = w_accept & ~w_bad;

    cv32e41p_fpu_req_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (flush_i),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_req),
        .o_data  (out_req_o),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign out_valid_o   = ~w_empty & ~rst & (r_outstanding < 4'(MAX_OUTSTANDING));
    assign w_pop         = out_valid_o & out_ready_i;
    assign out_opgroup_o = get_opgroup(out_req_o.op);
    assign empty_o       = w_empty;
    assign outstanding_o = r_outstanding;

    // A response with nothing outstanding is ignored rather than wrapping the counter.
    assign w_dec = resp_valid_i & (r_outstanding != 4'd0);

    always_ff @(posedge clk) begin
        if (rst) r_outstanding <= 4'd0;
        else     r_outstanding <= r_outstanding + 4'(w_pop) - 4'(w_dec);
    end

endmodule

// File: tb/tb_cv32e41p_fpu_req_queue.sv
// Directed self-checking bench for cv32e41p_fpu_req_queue (DEPTH=4, MAX_OUTSTANDING=2).
module tb_cv32e41p_fpu_req_queue;
    import cv32e41p_fpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [3:0]  in_op_i;
    logic        in_op_mod_i;
    logic [2:0]  in_src_fmt_i;
    logic [2:0]  in_dst_fmt_i;
    logic [1:0]  in_int_fmt_i;
    logic [2:0]  in_rm_i;
    logic [4:0]  in_tag_i;
    logic [95:0] in_operands_i;
    logic        out_valid_o;
    logic        out_ready_i;
    fpu_req_t    out_req_o;
    logic [1:0]  out_opgroup_o;
    logic        resp_valid_i;
    logic [3:0]  outstanding_o;
    logic        empty_o;
    logic        fmt_err_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    cv32e41p_fpu_req_queue #(
        .FLEN            (32),
        .NUM_OPERANDS    (3),
        .DEPTH           (4),
        .TAG_W           (5),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flush_i       (flush_i),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .in_op_i       (in_op_i),
        .in_op_mod_i   (in_op_mod_i),
        .in_src_fmt_i  (in_src_fmt_i),
        .in_dst_fmt_i  (in_dst_fmt_i),
        .in_int_fmt_i  (in_int_fmt_i),
        .in_rm_i       (in_rm_i),
        .in_tag_i      (in_tag_i),
        .in_operands_i (in_operands_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .out_req_o     (out_req_o),
        .out_opgroup_o (out_opgroup_o),
        .resp_valid_i  (resp_valid_i),
        .outstanding_o (outstanding_o),
        .empty_o       (empty_o),
        .fmt_err_o     (fmt_err_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] tag, input logic [3:0] op,
                         input logic [2:0] sfmt);
        in_valid_i    = v;
        in_tag_i      = tag;
        in_op_i       = op;
        in_src_fmt_i  = sfmt;
        in_operands_i = {3{27'h0, tag}};
    endtask

    initial begin
        rst = 1'b1; flush_i = 1'b0; out_ready_i = 1'b0; resp_valid_i = 1'b0;
        in_op_mod_i = 1'b0; in_dst_fmt_i = 3'd0; in_int_fmt_i = 2'd2; in_rm_i = 3'd0;
        drive(1'b1, 5'd9, 4'd2, 3'd0);

        // T1 reset
        repeat (3) step();
        chk("rst_empty", 32'(empty_o), 32'd1);
        chk("rst_out_valid", 32'(out_valid_o), 32'd0);
        chk("rst_in_ready", 32'(in_ready_o), 32'd0);
        chk("rst_outstanding", 32'(outstanding_o), 32'd0);
        chk("rst_fmt_err", 32'(fmt_err_o), 32'd0);
        rst = 1'b0;
        drive(1'b0, 5'd0, 4'd2, 3'd0);
        #1;
        chk("rel_in_ready", 32'(in_ready_o), 32'd1);

        // T2 fill and drain
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 5'(i), 4'd2, 3'd0);
            chk("fill_ready", 32'(in_ready_o), 32'd1);
            step();
        end
        drive(1'b1, 5'd5, 4'd2, 3'd0);
        chk("full_ready", 32'(in_ready_o), 32'd0);
        chk("full_head_tag", 32'(out_req_o.tag), 32'd1);
        step();
        chk("hold_valid", 32'(out_valid_o), 32'd1);
        chk("hold_tag", 32'(out_req_o.tag), 32'd1);
        chk("hold_operands", 32'(out_req_o.operands[31:0]), 32'd1);
        drive(1'b0, 5'd0, 4'd2, 3'd0);
        out_ready_i = 1'b1; resp_valid_i = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("drain_valid", 32'(out_valid_o), 32'd1);
            chk("drain_tag", 32'(out_req_o.tag), 32'(i));
            step();
        end
        chk("drain_empty", 32'(empty_o), 32'd1);
        chk("drain_out_valid", 32'(out_valid_o), 32'd0);
        chk("drain_outstanding", 32'(outstanding_o), 32'd1);
        out_ready_i = 1'b0;
        step();
        resp_valid_i = 1'b0;
        chk("drain_out_zero", 32'(outstanding_o), 32'd0);

        // T3 throttle
        out_ready_i = 1'b1;
        drive(1'b1, 5'd10, 4'd3, 3'd0);
        step();
        drive(1'b1, 5'd11, 4'd3, 3'd0);
        step();
        drive(1'b1, 5'd12, 4'd3, 3'd0);
        step();
        drive(1'b0, 5'd0, 4'd2, 3'd0);
        chk("thr_outstanding", 32'(outstanding_o), 32'd2);
        chk("thr_blocked", 32'(out_valid_o), 32'd0);
        chk("thr_head", 32'(out_req_o.tag), 32'd12);
        step();
        chk("thr_still_blocked", 32'(out_valid_o), 32'd0);
        resp_valid_i = 1'b1;
        step();
        resp_valid_i = 1'b0;
        chk("thr_after_resp", 32'(outstanding_o), 32'd1);
        chk("thr_reissue", 32'(out_valid_o), 32'd1);
        step();
        chk("thr_out_two", 32'(outstanding_o), 32'd2);
        chk("thr_empty", 32'(empty_o), 32'd1);

        // T4 classify
        out_ready_i = 1'b0; resp_valid_i = 1'b1;
        step();
        step();
        resp_valid_i = 1'b0;
        chk("cls_out_zero", 32'(outstanding_o), 32'd0);
        drive(1'b1, 5'd1, 4'd4, 3'd0);  step();
        drive(1'b1, 5'd2, 4'd6, 3'd0);  step();
        drive(1'b1, 5'd3, 4'd12, 3'd0); step();
        drive(1'b1, 5'd4, 4'd0, 3'd0);  step();
        drive(1'b0, 5'd0, 4'd2, 3'd0);
        out_ready_i = 1'b1; resp_valid_i = 1'b1;
        chk("cls_div", 32'(out_opgroup_o), 32'd1);  step();
        chk("cls_sgnj", 32'(out_opgroup_o), 32'd2); step();
        chk("cls_i2f", 32'(out_opgroup_o), 32'd3);  step();
        chk("cls_fmadd", 32'(out_opgroup_o), 32'd0); step();
        chk("cls_outstanding", 32'(outstanding_o), 32'd1);

        // T5 flush: pop in the flush cycle counts, push is dropped
        out_ready_i = 1'b0; resp_valid_i = 1'b0;
        drive(1'b1, 5'd20, 4'd2, 3'd0); step();
        drive(1'b1, 5'd21, 4'd2, 3'd0); step();
        drive(1'b1, 5'd22, 4'd2, 3'd0); step();
        drive(1'b1, 5'd23, 4'd2, 3'd0);
        flush_i = 1'b1; out_ready_i = 1'b1;
        step();
        flush_i = 1'b0; out_ready_i = 1'b0;
        drive(1'b0, 5'd0, 4'd2, 3'd0);
        chk("fl_empty", 32'(empty_o), 32'd1);
        chk("fl_out_valid", 32'(out_valid_o), 32'd0);
        chk("fl_outstanding", 32'(outstanding_o), 32'd2);
        resp_valid_i = 1'b1;
        step();
        step();
        resp_valid_i = 1'b0;
        chk("fl_drained_resp", 32'(outstanding_o), 32'd0);
        drive(1'b1, 5'd24, 4'd2, 3'd0);
        step();
        drive(1'b0, 5'd0, 4'd2, 3'd0);
        chk("fl_new_tag", 32'(out_req_o.tag), 32'd24);
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;
        chk("fl_new_empty", 32'(empty_o), 32'd1);
        resp_valid_i = 1'b1;
        step();
        resp_valid_i = 1'b0;

        // T6 format check: src_fmt=FP64
        drive(1'b1, 5'd7, 4'd2, 3'd1);
        chk("fmt_ready", 32'(in_ready_o), 32'd1);
        step();
        drive(1'b0, 5'd0, 4'd2, 3'd0);
`ifdef CV32E41P_FPU_FMT_CHECK_EN
        chk("fmt_err_pulse", 32'(fmt_err_o), 32'd1);
        chk("fmt_not_queued", 32'(empty_o), 32'd1);
        step();
        chk("fmt_err_clear", 32'(fmt_err_o), 32'd0);
        chk("fmt_still_empty", 32'(out_valid_o), 32'd0);
`else
        chk("fmt_err_tied", 32'(fmt_err_o), 32'd0);
        chk("fmt_queued", 32'(out_valid_o), 32'd1);
        chk("fmt_tag", 32'(out_req_o.tag), 32'd7);
        step();
        chk("fmt_err_tied2", 32'(fmt_err_o), 32'd0);
`endif

        // Reset mid-operation
        drive(1'b1, 5'd15, 4'd2, 3'd0);
        step();
        rst = 1'b1;
        drive(1'b0, 5'd0, 4'd2, 3'd0);
        step();
        rst = 1'b0;
        chk("mid_rst_empty", 32'(empty_o), 32'd1);
        chk("mid_rst_outstanding", 32'(outstanding_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
